// File: rtl/ghist_target_cache.sv
// Global-history-indexed branch target cache: per-lane banks of {valid, tag, dest}
// looked up per fetch group, with speculative GHR update, repair writes and a swept flush.
module ghist_target_cache #(
    parameter int ENTRIES  = 256,
    parameter int LANES    = 4,
    parameter int HIST_LEN = 4,
    parameter int TAG_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lk_valid,
    input  logic [31:0]           lk_vaddr,
    output logic                  lk_ready,
    output logic                  pred_valid,
    output logic [LANES-1:0]      pred_hit,
    output logic [LANES*32-1:0]   pred_dest,
    output logic [HIST_LEN-1:0]   pred_ckpt,
    input  logic                  spec_valid,
    input  logic                  spec_taken,
    input  logic                  rep_valid,
    input  logic [HIST_LEN-1:0]   rep_ckpt,
    input  logic [31:0]           rep_vaddr,
    input  logic                  rep_taken,
    input  logic [31:0]           rep_dest,
    input  logic                  flush
);

    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic {READY, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [HIST_LEN-1:0] ghr_q, ghr_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic                clr_en;

    logic [ENTRIES-1:0]  valid_q  [LANES];
    logic [TAG_W-1:0]    tag_mem  [LANES][ENTRIES];
    logic [31:0]         dest_mem [LANES][ENTRIES];

    logic                accept, wr_en;
    logic [LANE_W-1:0]   wr_lane;
    logic [IDX_W-1:0]    wr_idx, lk_idx;
    logic [TAG_W-1:0]    wr_tag, lk_tag;

    logic [31:0]         lane_addr [LANES];
    logic                ent_valid [LANES];
    logic [TAG_W-1:0]    ent_tag   [LANES];
    logic [31:0]         ent_dest  [LANES];
    logic [LANES-1:0]    hit_d;
    logic [LANES*32-1:0] dest_d;

    logic                unused_bits;

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] a, input logic [HIST_LEN-1:0] h);
        return a[IDX_W+LANE_W+1:LANE_W+2] ^ IDX_W'(h);
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
        return a[TAG_W+IDX_W+LANE_W+1:IDX_W+LANE_W+2];
    endfunction

    assign unused_bits = ^rep_vaddr;

    assign lk_ready = (state_q == READY);
    assign accept   = lk_valid && lk_ready && !flush;
    assign wr_en    = lk_ready && !flush && rep_valid && rep_taken;
    assign wr_lane  = rep_vaddr[LANE_W+1:2];
    assign wr_idx   = idx_of(rep_vaddr, rep_ckpt);
    assign wr_tag   = tag_of(rep_vaddr);
    assign lk_idx   = idx_of(lk_vaddr, ghr_q);
    assign lk_tag   = tag_of(lk_vaddr);

    always_comb begin
        state_d = state_q;
        ghr_d   = ghr_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        case (state_q)
            READY: begin
                if (flush) begin
                    state_d = CLEAR;
                    ghr_d   = '0;
                    cnt_d   = '0;
                end else if (rep_valid) begin
                    ghr_d = {rep_ckpt[HIST_LEN-2:0], rep_taken};
                end else if (spec_valid) begin
                    ghr_d = {ghr_q[HIST_LEN-2:0], spec_taken};
                end
            end
            CLEAR: begin
                clr_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(ENTRIES - 1))
                    state_d = READY;
            end
            default: state_d = READY;
        endcase
    end

    // A same-cycle repair to the looked-up slot is seen by the lookup (write-first)
    always_comb begin
        hit_d  = '0;
        dest_d = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_addr[l] = {lk_vaddr[31:LANE_W+2], LANE_W'(l), lk_vaddr[1:0]};
            if (wr_en && wr_lane == LANE_W'(l) && wr_idx == lk_idx) begin
                ent_valid[l] = 1'b1;
                ent_tag[l]   = wr_tag;
                ent_dest[l]  = rep_dest;
            end else begin
                ent_valid[l] = valid_q[l][lk_idx];
                ent_tag[l]   = tag_mem[l][lk_idx];
                ent_dest[l]  = dest_mem[l][lk_idx];
            end
            hit_d[l]           = ent_valid[l] && (ent_tag[l] == lk_tag);
            dest_d[32*l +: 32] = hit_d[l] ? ent_dest[l] : lane_addr[l] + 32'd8;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= READY;
            ghr_q      <= '0;
            cnt_q      <= '0;
            pred_valid <= 1'b0;
            pred_hit   <= '0;
            pred_dest  <= '0;
            pred_ckpt  <= '0;
        end else begin
            state_q    <= state_d;
            ghr_q      <= ghr_d;
            cnt_q      <= cnt_d;
            pred_valid <= accept;
            if (accept) begin
                pred_hit  <= hit_d;
                pred_dest <= dest_d;
                pred_ckpt <= ghr_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned l = 0; l < LANES; l++)
                valid_q[l] <= '0;
        end else if (clr_en) begin
            for (int unsigned l = 0; l < LANES; l++)
                valid_q[l][cnt_q] <= 1'b0;
        end else if (wr_en) begin
            valid_q[wr_lane][wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_lane][wr_idx]  <= wr_tag;
            dest_mem[wr_lane][wr_idx] <= rep_dest;
        end
    end

endmodule
